// File: rtl/rca4_bist_pkg.sv
// Shared types and constants for the 4-bit ripple-carry adder BIST engine.
package rca4_bist_pkg;

    localparam int          LFSR_W       = 16;
    // Feedback taps for x^16+x^14+x^13+x^11+1 in a left-shifting register
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        APPLY = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load and single-step advance.
module bist_lfsr
    import rca4_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VALUE = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [15:0]       value
);

    logic [LFSR_W-1:0] value_r;
    logic [LFSR_W-1:0] value_nxt_s;

    // Next-value selection: load wins over step
    always_comb begin
        value_nxt_s = value_r;
        if (load) begin
            value_nxt_s = seed;
        end else if (step) begin
            value_nxt_s = lfsr_next(value_r);
        end else begin
            value_nxt_s = value_r;
        end
    end

    // Shift register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= RESET_VALUE;
        end else begin
            value_r <= value_nxt_s;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/rca4_bist.sv
// BIST engine for a 4-bit adder: LFSR vectors, compare, count errors.
// Optional first-failure log enabled by defining BIST_ERRLOG_EN.
module rca4_bist
    import rca4_bist_pkg::*;
#(
    parameter logic [31:0] NUM_VECTORS = 32'd150,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  dut_a,
    output logic [3:0]  dut_b,
    output logic        dut_cin,
    input  logic [4:0]  dut_sum,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] vector_count,
    output logic [31:0] error_count
`ifdef BIST_ERRLOG_EN
    ,
    output logic        fail_valid,
    output logic [3:0]  fail_a,
    output logic [3:0]  fail_b,
    output logic        fail_cin,
    output logic [4:0]  fail_sum
`endif
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    state_t      state_r,    state_nxt_s;
    logic [3:0]  dut_a_r,    dut_a_nxt_s;
    logic [3:0]  dut_b_r,    dut_b_nxt_s;
    logic        dut_cin_r,  dut_cin_nxt_s;
    logic [4:0]  expected_r, expected_nxt_s;
    logic [31:0] vcnt_r,     vcnt_nxt_s;
    logic [31:0] ecnt_r,     ecnt_nxt_s;
    logic        busy_r,     busy_nxt_s;
    logic        done_r,     done_nxt_s;
    logic        pass_r,     pass_nxt_s;

    logic        lfsr_load_s;
    logic        lfsr_step_s;
    logic [15:0] lfsr_value_s;
    logic        lfsr_unused_s;
    logic        mismatch_s;

    bist_lfsr #(
        .RESET_VALUE (SEED_EFF)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_s),
        .seed  (SEED_EFF),
        .step  (lfsr_step_s),
        .value (lfsr_value_s)
    );

    assign lfsr_unused_s = ^lfsr_value_s[15:9];
    assign mismatch_s    = (dut_sum != expected_r);

    // Next-state and next-output logic for the run sequencer
    always_comb begin
        state_nxt_s    = state_r;
        dut_a_nxt_s    = dut_a_r;
        dut_b_nxt_s    = dut_b_r;
        dut_cin_nxt_s  = dut_cin_r;
        expected_nxt_s = expected_r;
        vcnt_nxt_s     = vcnt_r;
        ecnt_nxt_s     = ecnt_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = done_r;
        pass_nxt_s     = pass_r;
        lfsr_load_s    = 1'b0;
        lfsr_step_s    = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_load_s = 1'b1;
                    vcnt_nxt_s  = 32'd0;
                    ecnt_nxt_s  = 32'd0;
                    if (NUM_VECTORS == 32'd0) begin
                        state_nxt_s = DONE;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = APPLY;
                        busy_nxt_s  = 1'b1;
                        done_nxt_s  = 1'b0;
                        pass_nxt_s  = 1'b0;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            APPLY: begin
                dut_a_nxt_s    = lfsr_value_s[3:0];
                dut_b_nxt_s    = lfsr_value_s[7:4];
                dut_cin_nxt_s  = lfsr_value_s[8];
                expected_nxt_s = {1'b0, lfsr_value_s[3:0]} + {1'b0, lfsr_value_s[7:4]}
                               + {4'b0000, lfsr_value_s[8]};
                state_nxt_s    = CHECK;
            end
            CHECK: begin
                lfsr_step_s = 1'b1;
                vcnt_nxt_s  = vcnt_r + 32'd1;
                if (mismatch_s && (ecnt_r != 32'hFFFF_FFFF)) begin
                    ecnt_nxt_s = ecnt_r + 32'd1;
                end else begin
                    ecnt_nxt_s = ecnt_r;
                end
                // Counter reaching the programmed length ends the run
                if (vcnt_nxt_s == NUM_VECTORS) begin
                    state_nxt_s = DONE;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                    pass_nxt_s  = (ecnt_nxt_s == 32'd0);
                end else begin
                    state_nxt_s = APPLY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
                pass_nxt_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            dut_a_r    <= 4'h0;
            dut_b_r    <= 4'h0;
            dut_cin_r  <= 1'b0;
            expected_r <= 5'h00;
            vcnt_r     <= 32'd0;
            ecnt_r     <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            dut_a_r    <= dut_a_nxt_s;
            dut_b_r    <= dut_b_nxt_s;
            dut_cin_r  <= dut_cin_nxt_s;
            expected_r <= expected_nxt_s;
            vcnt_r     <= vcnt_nxt_s;
            ecnt_r     <= ecnt_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            pass_r     <= pass_nxt_s;
        end
    end

    assign dut_a        = dut_a_r;
    assign dut_b        = dut_b_r;
    assign dut_cin      = dut_cin_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign vector_count = vcnt_r;
    assign error_count  = ecnt_r;

`ifdef BIST_ERRLOG_EN
    logic       run_start_s;
    logic       fail_valid_r;
    logic [3:0] fail_a_r;
    logic [3:0] fail_b_r;
    logic       fail_cin_r;
    logic [4:0] fail_sum_r;

    assign run_start_s = start && ((state_r == IDLE) || (state_r == DONE));

    // First-failure capture, cleared when a new run is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid_r <= 1'b0;
            fail_a_r     <= 4'h0;
            fail_b_r     <= 4'h0;
            fail_cin_r   <= 1'b0;
            fail_sum_r   <= 5'h00;
        end else if (run_start_s) begin
            fail_valid_r <= 1'b0;
            fail_a_r     <= 4'h0;
            fail_b_r     <= 4'h0;
            fail_cin_r   <= 1'b0;
            fail_sum_r   <= 5'h00;
        end else if ((state_r == CHECK) && mismatch_s && !fail_valid_r) begin
            fail_valid_r <= 1'b1;
            fail_a_r     <= dut_a_r;
            fail_b_r     <= dut_b_r;
            fail_cin_r   <= dut_cin_r;
            fail_sum_r   <= dut_sum;
        end else begin
            fail_valid_r <= fail_valid_r;
            fail_a_r     <= fail_a_r;
            fail_b_r     <= fail_b_r;
            fail_cin_r   <= fail_cin_r;
            fail_sum_r   <= fail_sum_r;
        end
    end

    assign fail_valid = fail_valid_r;
    assign fail_a     = fail_a_r;
    assign fail_b     = fail_b_r;
    assign fail_cin   = fail_cin_r;
    assign fail_sum   = fail_sum_r;
`endif

endmodule

// File: tb/tb_rca4_bist.sv
// Directed bench for rca4_bist: vector table plus multi-cycle run scenarios.
module tb_rca4_bist;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start_one, start_zero, stuck0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Main instance (defaults) driving a behavioural adder with optional sum[0] stuck-at-0
    logic [3:0]  a0, b0;
    logic        cin0, busy0, done0, pass0;
    logic [4:0]  sum0, true0;
    logic [31:0] vc0, ec0;
    assign true0 = {1'b0, a0} + {1'b0, b0} + {4'b0000, cin0};
    assign sum0  = stuck0 ? {true0[4:1], 1'b0} : true0;

    logic [3:0]  a1, b1;
    logic        cin1, busy1, done1, pass1;
    logic [31:0] vc1, ec1;
    logic [4:0]  sum1;
    assign sum1 = {1'b0, a1} + {1'b0, b1} + {4'b0000, cin1};

    logic [3:0]  a2, b2;
    logic        cin2, busy2, done2, pass2;
    logic [31:0] vc2, ec2;
    logic [4:0]  sum2;
    assign sum2 = {1'b0, a2} + {1'b0, b2} + {4'b0000, cin2};

`ifdef BIST_ERRLOG_EN
    logic       fv0, fc0, fv1, fc1, fv2, fc2;
    logic [3:0] fa0, fb0, fa1, fb1, fa2, fb2;
    logic [4:0] fs0, fs1, fs2;
`endif

    rca4_bist u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_sum(sum0),
        .busy(busy0), .done(done0), .pass(pass0),
        .vector_count(vc0), .error_count(ec0)
`ifdef BIST_ERRLOG_EN
        , .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_cin(fc0), .fail_sum(fs0)
`endif
    );

    rca4_bist #(.NUM_VECTORS(32'd1), .SEED(16'h0001)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start_one),
        .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(sum1),
        .busy(busy1), .done(done1), .pass(pass1),
        .vector_count(vc1), .error_count(ec1)
`ifdef BIST_ERRLOG_EN
        , .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_cin(fc1), .fail_sum(fs1)
`endif
    );

    rca4_bist #(.NUM_VECTORS(32'd0)) u_zero (
        .clk(clk), .rst_n(rst_n), .start(start_zero),
        .dut_a(a2), .dut_b(b2), .dut_cin(cin2), .dut_sum(sum2),
        .busy(busy2), .done(done2), .pass(pass2),
        .vector_count(vc2), .error_count(ec2)
`ifdef BIST_ERRLOG_EN
        , .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2), .fail_cin(fc2), .fail_sum(fs2)
`endif
    );

    vec_t tab [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start on the main instance and counts busy cycles; called at a negedge
    task automatic run_main(input bit chk_tab, input int pulse_at, output int busy_cycles);
        int k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (busy0 && (k < 2000)) begin
            if (chk_tab && (k % 2 == 1) && (k / 2 < 6)) begin
                check($sformatf("vec%0d_a", k / 2),   {28'd0, a0}, {28'd0, tab[k / 2].a});
                check($sformatf("vec%0d_b", k / 2),   {28'd0, b0}, {28'd0, tab[k / 2].b});
                check($sformatf("vec%0d_cin", k / 2), {31'd0, cin0}, {31'd0, tab[k / 2].cin});
            end
            start = (k == pulse_at) ? 1'b1 : 1'b0;
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check("run_timeout", {31'd0, (k < 2000)}, 32'd1);
        busy_cycles = k;
    endtask

    initial begin
        logic [15:0] m;
        logic [4:0]  ms;
        int          odd_cnt, cycles;
        bit          found;
        logic [3:0]  first_a, first_b, last_a, last_b;
        logic        first_cin, last_cin;
        logic [4:0]  first_sum;

        // Hand-computed first six vectors from seed ACE1
        tab[0] = '{a: 4'h1, b: 4'hE, cin: 1'b0};   // ACE1
        tab[1] = '{a: 4'h3, b: 4'hC, cin: 1'b1};   // 59C3
        tab[2] = '{a: 4'h7, b: 4'h8, cin: 1'b1};   // B387
        tab[3] = '{a: 4'hF, b: 4'h0, cin: 1'b1};   // 670F
        tab[4] = '{a: 4'hE, b: 4'h1, cin: 1'b0};   // CE1E
        tab[5] = '{a: 4'hC, b: 4'h3, cin: 1'b0};   // 9C3C

        // Reference sequence: odd-sum count, first odd vector, last vector
        m = 16'hACE1; odd_cnt = 0; found = 1'b0;
        first_a = 4'h0; first_b = 4'h0; first_cin = 1'b0; first_sum = 5'h00;
        last_a = 4'h0; last_b = 4'h0; last_cin = 1'b0;
        for (int i = 0; i < 150; i++) begin
            ms = {1'b0, m[3:0]} + {1'b0, m[7:4]} + {4'b0000, m[8]};
            if (ms[0]) begin
                odd_cnt++;
                if (!found) begin
                    first_a = m[3:0]; first_b = m[7:4]; first_cin = m[8];
                    first_sum = {ms[4:1], 1'b0};
                end
                found = 1'b1;
            end
            last_a = m[3:0]; last_b = m[7:4]; last_cin = m[8];
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end

        rst_n = 1'b0; start = 1'b0; start_one = 1'b0; start_zero = 1'b0; stuck0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_pass", {31'd0, pass0}, 32'd0);
        check("rst_vcnt", vc0, 32'd0);
        check("rst_ecnt", ec0, 32'd0);
        check("rst_a", {28'd0, a0}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", {31'd0, busy0}, 32'd0);
        check("idle_done", {31'd0, done0}, 32'd0);

        // Clean run with a stray start pulse mid-run
        run_main(1'b1, 41, cycles);
        check("clean_cycles", cycles, 32'd300);
        check("clean_done", {31'd0, done0}, 32'd1);
        check("clean_pass", {31'd0, pass0}, 32'd1);
        check("clean_vcnt", vc0, 32'd150);
        check("clean_ecnt", ec0, 32'd0);
        repeat (5) @(negedge clk);
        check("hold_done", {31'd0, done0}, 32'd1);
        check("hold_vcnt", vc0, 32'd150);
        check("hold_a", {28'd0, a0}, {28'd0, last_a});
        check("hold_b", {28'd0, b0}, {28'd0, last_b});
        check("hold_cin", {31'd0, cin0}, {31'd0, last_cin});

        // Faulty adder: restart from DONE
        stuck0 = 1'b1;
        run_main(1'b0, -1, cycles);
        check("stuck_cycles", cycles, 32'd300);
        check("stuck_done", {31'd0, done0}, 32'd1);
        check("stuck_pass", {31'd0, pass0}, 32'd0);
        check("stuck_ecnt", ec0, odd_cnt);
        check("stuck_vcnt", vc0, 32'd150);
`ifdef BIST_ERRLOG_EN
        check("log_valid", {31'd0, fv0}, 32'd1);
        check("log_a", {28'd0, fa0}, {28'd0, first_a});
        check("log_b", {28'd0, fb0}, {28'd0, first_b});
        check("log_cin", {31'd0, fc0}, {31'd0, first_cin});
        check("log_sum", {27'd0, fs0}, {27'd0, first_sum});
`endif

        // Reset during the 10th CHECK cycle
        stuck0 = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy0}, 32'd1);
        check("pre_rst_vcnt", vc0, 32'd9);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_done", {31'd0, done0}, 32'd0);
        check("midrst_pass", {31'd0, pass0}, 32'd0);
        check("midrst_vcnt", vc0, 32'd0);
        check("midrst_ecnt", ec0, 32'd0);
        check("midrst_a", {28'd0, a0}, 32'd0);
        check("midrst_b", {28'd0, b0}, 32'd0);
        check("midrst_cin", {31'd0, cin0}, 32'd0);
`ifdef BIST_ERRLOG_EN
        check("midrst_log", {31'd0, fv0}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_main(1'b1, -1, cycles);
        check("rerun_cycles", cycles, 32'd300);
        check("rerun_pass", {31'd0, pass0}, 32'd1);
        check("rerun_vcnt", vc0, 32'd150);
        check("rerun_ecnt", ec0, 32'd0);

        // Single-vector instance, seed 0001
        start_one = 1'b1;
        @(negedge clk);
        start_one = 1'b0;
        check("one_busy0", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        check("one_a", {28'd0, a1}, 32'd1);
        check("one_b", {28'd0, b1}, 32'd0);
        check("one_cin", {31'd0, cin1}, 32'd0);
        check("one_busy1", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        check("one_busy_end", {31'd0, busy1}, 32'd0);
        check("one_done", {31'd0, done1}, 32'd1);
        check("one_pass", {31'd0, pass1}, 32'd1);
        check("one_vcnt", vc1, 32'd1);

        // Zero-vector instance completes immediately
        check("zero_idle_done", {31'd0, done2}, 32'd0);
        start_zero = 1'b1;
        @(negedge clk);
        start_zero = 1'b0;
        check("zero_done", {31'd0, done2}, 32'd1);
        check("zero_pass", {31'd0, pass2}, 32'd1);
        check("zero_busy", {31'd0, busy2}, 32'd0);
        check("zero_vcnt", vc2, 32'd0);
        check("zero_ecnt", ec2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rca4_bist.md
RCA4_BIST -- requirements
Module: rca4_bist

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 150: number of vectors applied per run (0..2^32-1).
REQ-002 SHALL have parameter SEED, default 16'hACE1: LFSR start value; a value of 0 SHALL be replaced by 16'hACE1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: run request pulse.
REQ-006 SHALL have port dut_a, output, 4: addend A driven to the adder under test.
REQ-007 SHALL have port dut_b, output, 4: addend B driven to the adder under test.
REQ-008 SHALL have port dut_cin, output, 1: carry-in driven to the adder under test.
REQ-009 SHALL have port dut_sum, input, 5: {cout,sum} returned combinationally by the adder under test.
REQ-010 SHALL have port busy, output, 1: run in progress.
REQ-011 SHALL have port done, output, 1: run complete; results valid.
REQ-012 SHALL have port pass, output, 1: high when done and error_count is 0.
REQ-013 SHALL have port vector_count, output, 32: vectors checked in the current or last run.
REQ-014 SHALL have port error_count, output, 32: mismatches in the current or last run.

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, CHECK, DONE.
REQ-016 IDLE or DONE with start=1 SHALL go to APPLY, clear both counts, reload the LFSR with SEED, and deassert done/pass.
REQ-017 If NUM_VECTORS is 0, start SHALL go directly to DONE with pass=1 and both counts 0.
REQ-018 APPLY SHALL register dut_a=lfsr[3:0], dut_b=lfsr[7:4], dut_cin=lfsr[8], register expected={1'b0,A}+{1'b0,B}+cin (5 bits), and go to CHECK.
REQ-019 CHECK SHALL compare dut_sum against expected and increment vector_count.
REQ-020 On a CHECK mismatch, error_count SHALL increment, saturating at 32'hFFFFFFFF.
REQ-021 CHECK SHALL advance the LFSR one step and go to APPLY; if the new vector_count equals NUM_VECTORS, it SHALL go to DONE instead.
REQ-022 Each vector SHALL take exactly 2 cycles; a run SHALL last 2*NUM_VECTORS cycles in APPLY/CHECK.
REQ-023 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering at bit 0.
REQ-024 busy SHALL be 1 exactly in APPLY and CHECK.
REQ-025 done SHALL be 1 exactly in DONE; pass SHALL be done AND (error_count==0).
REQ-026 start while busy SHALL be ignored.
REQ-027 DONE SHALL hold, with counts and outputs stable, until start or reset.
REQ-028 dut_* outputs SHALL hold their last value outside APPLY.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, LFSR=SEED, dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, pass=0, vector_count=0, error_count=0, including mid-run.
REQ-030 After rst_n rises, the block SHALL stay in IDLE until start.

Configuration
REQ-031 With BIST_ERRLOG_EN defined, the block SHALL add outputs fail_valid(1), fail_a(4), fail_b(4), fail_cin(1), fail_sum(5), capturing the first mismatching vector and its dut_sum, held until the next start or reset (cleared to 0 then).
REQ-032 Without BIST_ERRLOG_EN, those ports and their registers SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-033 Package rca4_bist_pkg SHALL hold the state enum, the LFSR width (16), the tap mask, and the default seed constant.
REQ-034 The LFSR SHALL be sub-module bist_lfsr with ports clk, rst_n, load, seed, step, and value[15:0].

Verification
REQ-035 Correct behavioural adder, pulse start: busy for 300 cycles, then done=1, pass=1, vector_count=150, error_count=0.
REQ-036 Adder with sum[0] stuck at 0: done reached with error_count >0 and equal to the number of vectors with odd true sum; pass=0.
REQ-037 Drop rst_n in the 10th CHECK: all outputs return to reset values at once; a new start gives a full clean 150-vector run.
REQ-038 Pulse start mid-run: no restart; total run length stays 300 cycles.
REQ-039 NUM_VECTORS=1, SEED=16'h0001: dut_a=1, dut_b=0, dut_cin=0, expected=5'h01; done after 2 busy cycles with vector_count=1.
REQ-040 BIST_ERRLOG_EN with a faulty adder: fail_* match the first mismatching vector and stay fixed despite later errors.
